// File: rtl/rr_ring_arbiter_pkg.sv
// Shared types and constants for the round-robin ring arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state encoding, width of the binary owner index.
package rr_ring_arbiter_pkg;

  // Binary owner index width; N is capped at 16 so 4 bits always suffice.
  localparam int IDX_W = 4;
  localparam int N_MAX = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/rr_ring_arbiter_if.sv
// Bundle of request/grant signals between requesters and the arbiter.
// Latency: n/a (wires only).
// Backpressure: n/a; requesters hold req until done, the arbiter answers with grant.
//
// master : requester side (drives en/req, observes grant/ptr)
// slave  : arbiter side (consumes en/req, drives grant/grant_vld/grant_idx/ptr)
interface rr_ring_arbiter_if #(
  parameter int N = 8
) ();
  import rr_ring_arbiter_pkg::*;

  logic             en;
  logic [N-1:0]     req;
  logic [N-1:0]     grant;
  logic             grant_vld;
  logic [IDX_W-1:0] grant_idx;
  logic [N-1:0]     ptr;

  modport master (
    output en, req,
    input  grant, grant_vld, grant_idx, ptr
  );

  modport slave (
    input  en, req,
    output grant, grant_vld, grant_idx, ptr
  );
endinterface

// File: rtl/rr_ring_arbiter_pick.sv
// Round-robin pick: first set req bit at or above the one-hot ptr, wrapping.
// Latency: combinational, 0 cycles.
// Backpressure: none; pure function of req_i and ptr_i.
//
// req_i        : request vector
// ptr_i        : one-hot priority pointer (search starts here)
// winner_o     : one-hot winner, zero when no request
// winner_idx_o : binary winner index, zero when no request
// any_o        : at least one request present
module rr_pick
  import rr_ring_arbiter_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]     req_i,
  input  logic [N-1:0]     ptr_i,
  output logic [N-1:0]     winner_o,
  output logic [IDX_W-1:0] winner_idx_o,
  output logic             any_o
);

  // Lower copy keeps only bits at/above ptr (ptr-1 is the mask of bits below
  // a one-hot ptr); upper copy supplies the wrapped-around candidates.
  logic [2*N-1:0] dbl;
  assign dbl = {req_i, req_i & ~(ptr_i - N'(1))};

  always_comb begin
    winner_o     = '0;
    winner_idx_o = '0;
    any_o        = 1'b0;
    for (int i = 0; i < 2 * N; i++) begin
      if (!any_o && dbl[i]) begin
        any_o        = 1'b1;
        winner_idx_o = IDX_W'(i % N);
        winner_o     = N'(1) << (i % N);
      end
    end
  end

endmodule

// File: rtl/rr_ring_arbiter.sv
// Round-robin arbiter with a one-hot rotating pointer and optional tenure limit.
// Latency: 1 clock from req to grant; hand-off to the next owner has no bubble.
// Backpressure: owner keeps grant while requesting; en=0 blocks new grants only.
//
// clk  : rising-edge clock
// rst  : asynchronous active-low reset
// bus  : slave side of rr_ring_arbiter_if (en, req in; grant, grant_vld, grant_idx, ptr out)
// N must be 2..16; MAX_HOLD=0 means unlimited tenure.
module rr_ring_arbiter
  import rr_ring_arbiter_pkg::*;
#(
  parameter int N        = 8,
  parameter int CW       = 8,
  parameter int MAX_HOLD = 0
) (
  input  logic             clk,
  input  logic             rst,
  rr_ring_arbiter_if.slave bus
);

  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
  localparam logic [CW-1:0] HOLD_LAST = CW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  state_e           state_q, state_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic [N-1:0]     ptr_q,   ptr_d;
  logic [CW-1:0]    cnt_q,   cnt_d;

  logic             busy;
  logic             owner_req;
  logic             release_w;
  logic             expire_w;
  logic             handoff;
  logic [N-1:0]     ptr_rot;
  logic [N-1:0]     pick_ptr;
  logic [N-1:0]     pick_req;
  logic [N-1:0]     win;
  logic [IDX_W-1:0] win_idx;
  logic             win_any;

  assign busy      = (state_q == ST_BUSY);
  assign owner_req = |(bus.req & grant_q);
  assign release_w = busy && !owner_req;
  assign expire_w  = busy && (MAX_HOLD != 0) && (cnt_q == HOLD_LAST);
  assign handoff   = release_w || expire_w;

  // Owner is one-hot in grant_q, so rotating it left gives onehot((o+1) mod N).
  assign ptr_rot  = {grant_q[N-2:0], grant_q[N-1]};

  // On hand-off the pick must already see the rotated pointer and must not
  // re-select the outgoing owner (it may still be requesting on expiry).
  assign pick_ptr = handoff ? ptr_rot : ptr_q;
  assign pick_req = busy ? (bus.req & ~grant_q) : bus.req;

  rr_pick #(
    .N (N)
  ) u_pick (
    .req_i        (pick_req),
    .ptr_i        (pick_ptr),
    .winner_o     (win),
    .winner_idx_o (win_idx),
    .any_o        (win_any)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= N'(1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.en && win_any) begin
          state_d = ST_BUSY;
          grant_d = win;
          idx_d   = win_idx;
          cnt_d   = '0;
        end
      end
      ST_BUSY: begin
        if (!handoff) begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
        end else begin
          ptr_d = ptr_rot;
          if (bus.en && win_any) begin
            grant_d = win;
            idx_d   = win_idx;
            cnt_d   = '0;
          end else if (bus.en && !release_w) begin
            // Expiry with nobody else waiting: owner keeps the grant.
            cnt_d = '0;
          end else begin
            state_d = ST_IDLE;
            grant_d = '0;
            idx_d   = '0;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.grant     = grant_q;
  assign bus.grant_vld = |grant_q;
  assign bus.grant_idx = idx_q;
  assign bus.ptr       = ptr_q;

endmodule

// File: tb/tb_rr_ring_arbiter.sv
// Self-checking bench for rr_ring_arbiter: two N=4 instances (MAX_HOLD 0 and 4).
// Latency: n/a.
// Backpressure: n/a.
module tb_rr_ring_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rr_ring_arbiter_if #(.N(4)) b0 ();
  rr_ring_arbiter_if #(.N(4)) b4 ();

  rr_ring_arbiter #(.N(4), .CW(8), .MAX_HOLD(0)) u_dut0 (.clk(clk), .rst(rst), .bus(b0));
  rr_ring_arbiter #(.N(4), .CW(8), .MAX_HOLD(4)) u_dut4 (.clk(clk), .rst(rst), .bus(b4));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int oh2i(input logic [3:0] g);
    int r;
    r = 0;
    for (int i = 0; i < 4; i++) if (g[i]) r = i;
    return r;
  endfunction

  task automatic drive(input int d, input logic e, input logic [3:0] r);
    if (d == 0) begin b0.en = e; b0.req = r; end
    else        begin b4.en = e; b4.req = r; end
  endtask

  task automatic chk_out(input string tag, input int d, input logic [3:0] g, input logic [3:0] p);
    logic [3:0] ag, ap, ai;
    logic       av;
    if (d == 0) begin ag = b0.grant; av = b0.grant_vld; ai = b0.grant_idx; ap = b0.ptr; end
    else        begin ag = b4.grant; av = b4.grant_vld; ai = b4.grant_idx; ap = b4.ptr; end
    chk({tag, " grant"}, 32'(ag), 32'(g));
    chk({tag, " grant_vld"}, 32'(av), 32'(|g));
    chk({tag, " grant_idx"}, 32'(ai), 32'(oh2i(g)));
    chk({tag, " ptr"}, 32'(ap), 32'(p));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural reference model ----------------
  bit m_busy [2];
  int m_own  [2];
  int m_p    [2];
  int m_cnt  [2];
  int m_hold [2] = '{0, 4};

  // First requester at or after 'start', circularly, skipping 'skip'.
  function automatic int pick(input logic [3:0] r, input int start, input int skip);
    int i;
    for (int k = 0; k < 4; k++) begin
      i = (start + k) % 4;
      if (r[i] && i != skip) return i;
    end
    return -1;
  endfunction

  task automatic m_reset();
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = 1'b0; m_own[d] = 0; m_p[d] = 0; m_cnt[d] = 0;
    end
  endtask

  task automatic m_step(input int d, input logic e, input logic [3:0] r);
    int w;
    bit rel, ex;
    if (!m_busy[d]) begin
      if (e && r != 4'b0000) begin
        m_own[d] = pick(r, m_p[d], -1); m_busy[d] = 1'b1; m_cnt[d] = 0;
      end
    end else begin
      rel = !r[m_own[d]];
      ex  = (m_hold[d] != 0) && (m_cnt[d] == m_hold[d] - 1);
      if (!rel && !ex) begin
        m_cnt[d] = (m_cnt[d] == 255) ? 255 : m_cnt[d] + 1;
      end else begin
        m_p[d] = (m_own[d] + 1) % 4;
        w = e ? pick(r, m_p[d], m_own[d]) : -1;
        if (w >= 0)          begin m_own[d] = w; m_cnt[d] = 0; end
        else if (e && !rel)  m_cnt[d] = 0;
        else                 begin m_busy[d] = 1'b0; m_cnt[d] = 0; end
      end
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit         rs;   // pulse reset before this row
    int         d;    // 0: MAX_HOLD=0 instance, 1: MAX_HOLD=4 instance
    logic       en;
    logic [3:0] req;
    logic [3:0] g;    // expected grant after the edge
    logic [3:0] p;    // expected ptr after the edge
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit rs, input int d, input logic e, input logic [3:0] r,
                     input logic [3:0] g, input logic [3:0] p);
    vec_t v;
    v.rs = rs; v.d = d; v.en = e; v.req = r; v.g = g; v.p = p;
    tbl.push_back(v);
  endtask

  initial begin
    logic [3:0] rq [2];
    logic       en_r [2];
    logic [3:0] eg, ep;

    drive(0, 1'b0, 4'b0000);
    drive(1, 1'b0, 4'b0000);

    // Basic grant, release hand-off, then wrap from a non-zero pointer.
    add(1, 0, 1, 4'b0110, 4'b0010, 4'b0001);
    add(0, 0, 1, 4'b0100, 4'b0100, 4'b0100);
    add(0, 0, 1, 4'b0000, 4'b0000, 4'b1000);
    add(0, 0, 1, 4'b0011, 4'b0001, 4'b1000);
    // All requesting, owner drops for one cycle after two: order 0,1,2,3,0.
    add(1, 0, 1, 4'b1111, 4'b0001, 4'b0001);
    add(0, 0, 1, 4'b1111, 4'b0001, 4'b0001);
    add(0, 0, 1, 4'b1110, 4'b0010, 4'b0010);
    add(0, 0, 1, 4'b1111, 4'b0010, 4'b0010);
    add(0, 0, 1, 4'b1101, 4'b0100, 4'b0100);
    add(0, 0, 1, 4'b1111, 4'b0100, 4'b0100);
    add(0, 0, 1, 4'b1011, 4'b1000, 4'b1000);
    add(0, 0, 1, 4'b1111, 4'b1000, 4'b1000);
    add(0, 0, 1, 4'b0111, 4'b0001, 4'b0001);
    // MAX_HOLD=4, two requesters: 4 cycles each, alternating.
    add(1, 1, 1, 4'b0011, 4'b0001, 4'b0001);
    add(0, 1, 1, 4'b0011, 4'b0001, 4'b0001);
    add(0, 1, 1, 4'b0011, 4'b0001, 4'b0001);
    add(0, 1, 1, 4'b0011, 4'b0001, 4'b0001);
    add(0, 1, 1, 4'b0011, 4'b0010, 4'b0010);
    add(0, 1, 1, 4'b0011, 4'b0010, 4'b0010);
    add(0, 1, 1, 4'b0011, 4'b0010, 4'b0010);
    add(0, 1, 1, 4'b0011, 4'b0010, 4'b0010);
    add(0, 1, 1, 4'b0011, 4'b0001, 4'b0100);
    // MAX_HOLD=4, sole requester 2: grant held, ptr moves to bit 3 and stays.
    add(1, 1, 1, 4'b0100, 4'b0100, 4'b0001);
    add(0, 1, 1, 4'b0100, 4'b0100, 4'b0001);
    add(0, 1, 1, 4'b0100, 4'b0100, 4'b0001);
    add(0, 1, 1, 4'b0100, 4'b0100, 4'b0001);
    add(0, 1, 1, 4'b0100, 4'b0100, 4'b1000);
    add(0, 1, 1, 4'b0100, 4'b0100, 4'b1000);
    add(0, 1, 1, 4'b0100, 4'b0100, 4'b1000);
    add(0, 1, 1, 4'b0100, 4'b0100, 4'b1000);
    add(0, 1, 1, 4'b0100, 4'b0100, 4'b1000);
    // en gating: blocked in IDLE, ignored while owned, drop to IDLE on release.
    add(1, 0, 0, 4'b1000, 4'b0000, 4'b0001);
    add(0, 0, 0, 4'b1000, 4'b0000, 4'b0001);
    add(0, 0, 1, 4'b1000, 4'b1000, 4'b0001);
    add(0, 0, 0, 4'b1000, 4'b1000, 4'b0001);
    add(0, 0, 0, 4'b1000, 4'b1000, 4'b0001);
    add(0, 0, 0, 4'b0000, 4'b0000, 4'b0001);
    add(0, 0, 0, 4'b0001, 4'b0000, 4'b0001);
    add(0, 0, 1, 4'b0001, 4'b0001, 4'b0001);
    // Expiry with en=0 behaves as release.
    add(1, 1, 1, 4'b0100, 4'b0100, 4'b0001);
    add(0, 1, 0, 4'b0100, 4'b0100, 4'b0001);
    add(0, 1, 0, 4'b0100, 4'b0100, 4'b0001);
    add(0, 1, 0, 4'b0100, 4'b0100, 4'b0001);
    add(0, 1, 0, 4'b0100, 4'b0000, 4'b1000);

    // Reset state, observed while reset is held.
    #12;
    chk_out("reset0", 0, 4'b0000, 4'b0001);
    chk_out("reset4", 1, 4'b0000, 4'b0001);
    rst = 1'b1;
    step();

    foreach (tbl[i]) begin
      if (tbl[i].rs) begin
        rst = 1'b0;
        #2;
        rst = 1'b1;
      end
      drive(tbl[i].d, tbl[i].en, tbl[i].req);
      drive(1 - tbl[i].d, 1'b0, 4'b0000);
      step();
      chk_out($sformatf("vec%0d", i), tbl[i].d, tbl[i].g, tbl[i].p);
    end

    // Asynchronous reset in the middle of a grant.
    rst = 1'b0; #2; rst = 1'b1;
    drive(0, 1'b1, 4'b0110);
    drive(1, 1'b1, 4'b0110);
    step();
    drive(0, 1'b1, 4'b0100);
    drive(1, 1'b1, 4'b0100);
    step();
    chk_out("pre_arst0", 0, 4'b0100, 4'b0100);
    chk_out("pre_arst4", 1, 4'b0100, 4'b0100);
    #2;
    rst = 1'b0;
    #1;
    chk_out("arst0", 0, 4'b0000, 4'b0001);
    chk_out("arst4", 1, 4'b0000, 4'b0001);
    #2;
    rst = 1'b1;
    drive(0, 1'b1, 4'b1110);
    drive(1, 1'b1, 4'b1110);
    step();
    chk_out("post_arst0", 0, 4'b0010, 4'b0001);
    chk_out("post_arst4", 1, 4'b0010, 4'b0001);

    // Randomized traffic against the reference model.
    rst = 1'b0; #2; rst = 1'b1;
    m_reset();
    rq[0] = 4'b0000; rq[1] = 4'b0000;
    for (int c = 0; c < 3000; c++) begin
      for (int d = 0; d < 2; d++) begin
        for (int b = 0; b < 4; b++)
          if ($urandom_range(0, 5) == 0) rq[d][b] = ~rq[d][b];
        en_r[d] = ($urandom_range(0, 7) != 0);
        drive(d, en_r[d], rq[d]);
      end
      step();
      for (int d = 0; d < 2; d++) begin
        m_step(d, en_r[d], rq[d]);
        eg = m_busy[d] ? (4'b0001 << m_own[d]) : 4'b0000;
        ep = 4'b0001 << m_p[d];
        chk_out($sformatf("rnd%0d_c%0d", d, c), d, eg, ep);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
